traffic_ctrl_rr: RTL and testbench

Parametrised N-way traffic-light controller with demand-driven round-robin phasing. Each approach presents a vehicle request. The controller grants green to one approach at a time, steps through yellow and an optional all-red clearance, and serves the next requesting approach in round-robin order. If no other approach is waiting, the current green is held. It sits at the top of the intersection datapath and directly drives per-approach lamp codes: 001 green, 010 yellow, 100 red.

---
 rtl/traffic_ctrl_rr.sv | 171 +++++++++++++++++
 tb/tb_traffic_ctrl_rr.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/traffic_ctrl_rr.sv
// N-way traffic-light controller: round-robin green among requesting approaches, then yellow and optional all-red.
// Optional feature macro: TL_ALL_RED_EN inserts an ALLRED clearance phase between YELLOW and GREEN.
module traffic_ctrl_rr #(
    parameter int N_DIR         = 4,
    parameter int GREEN_CYCLES  = 8,
    parameter int YELLOW_CYCLES = 4,
    parameter int ALLRED_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_DIR-1:0]         req,
    output logic [3*N_DIR-1:0]       lights,
    output logic [$clog2(N_DIR)-1:0] grant_dir,
    output logic [1:0]               phase,
    output logic                     phase_start
);
    localparam int DIR_W  = $clog2(N_DIR);
    localparam int MAX_GY = (GREEN_CYCLES > YELLOW_CYCLES) ? GREEN_CYCLES : YELLOW_CYCLES;
`ifdef TL_ALL_RED_EN
    localparam int MAX_DUR = (MAX_GY > ALLRED_CYCLES) ? MAX_GY : ALLRED_CYCLES;
`else
    localparam int MAX_DUR = MAX_GY;
`endif
    localparam int CNT_W = $clog2(MAX_DUR) + 1;
    localparam logic [CNT_W-1:0] G_LAST = CNT_W'(GREEN_CYCLES - 1);
    localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(YELLOW_CYCLES - 1);
`ifdef TL_ALL_RED_EN
    localparam logic [CNT_W-1:0] A_LAST = CNT_W'(ALLRED_CYCLES - 1);
`endif

    typedef enum logic [1:0] {
        PH_GREEN  = 2'b00,
        PH_YELLOW = 2'b01,
        PH_ALLRED = 2'b10
    } phase_t;

    phase_t             phase_q, phase_d;
    logic [DIR_W-1:0]   grant_q, grant_d;
    logic [DIR_W-1:0]   next_q, next_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_DIR-1:0]   pending_q, pending_d;
    logic               phase_start_q, phase_start_d;

    logic [N_DIR-1:0]   set_vec;
    logic [N_DIR-1:0]   pend_eff;
    logic               hit;
    logic [DIR_W-1:0]   hit_dir;
    logic               enter_green;
    int                 best_off;
    int                 off;

    // Requests for the approach currently in green are dropped; the rest bypass into the search.
    always_comb begin
        set_vec = '0;
        for (int d = 0; d < N_DIR; d++) begin
            set_vec[d] = req[d] && !(phase_q == PH_GREEN && DIR_W'(d) == grant_q);
        end
        pend_eff = pending_q | set_vec;
    end

    // Round-robin search: smallest nonzero offset after the current grant wins.
    always_comb begin
        best_off = N_DIR;
        off      = 0;
        hit_dir  = '0;
        for (int d = 0; d < N_DIR; d++) begin
            off = (d + N_DIR - int'(grant_q)) % N_DIR;
            if (pend_eff[d] && off != 0 && off < best_off) begin
                best_off = off;
                hit_dir  = DIR_W'(d);
            end
        end
        hit = (best_off < N_DIR);
    end

    always_comb begin
        phase_d       = phase_q;
        grant_d       = grant_q;
        next_d        = next_q;
        cnt_d         = cnt_q;
        phase_start_d = 1'b0;
        enter_green   = 1'b0;
        case (phase_q)
            PH_GREEN: begin
                if (cnt_q == G_LAST) begin
                    if (hit) begin
                        next_d        = hit_dir;
                        phase_d       = PH_YELLOW;
                        cnt_d         = '0;
                        phase_start_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PH_YELLOW: begin
                if (cnt_q == Y_LAST) begin
                    cnt_d         = '0;
                    phase_start_d = 1'b1;
`ifdef TL_ALL_RED_EN
                    phase_d       = PH_ALLRED;
`else
                    phase_d       = PH_GREEN;
                    grant_d       = next_q;
                    enter_green   = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef TL_ALL_RED_EN
            PH_ALLRED: begin
                if (cnt_q == A_LAST) begin
                    cnt_d         = '0;
                    phase_start_d = 1'b1;
                    phase_d       = PH_GREEN;
                    grant_d       = next_q;
                    enter_green   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            default: begin
                phase_d       = PH_GREEN;
                cnt_d         = '0;
                phase_start_d = 1'b1;
            end
        endcase
        pending_d = pend_eff;
        if (enter_green) begin
            pending_d[next_q] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q       <= PH_GREEN;
            grant_q       <= '0;
            next_q        <= '0;
            cnt_q         <= '0;
            pending_q     <= '0;
            phase_start_q <= 1'b1;
        end else begin
            phase_q       <= phase_d;
            grant_q       <= grant_d;
            next_q        <= next_d;
            cnt_q         <= cnt_d;
            pending_q     <= pending_d;
            phase_start_q <= phase_start_d;
        end
    end

    always_comb begin
        lights = '0;
        for (int d = 0; d < N_DIR; d++) begin
            if (phase_q == PH_GREEN && DIR_W'(d) == grant_q) begin
                lights[3*d +: 3] = 3'b001;
            end else if (phase_q == PH_YELLOW && DIR_W'(d) == grant_q) begin
                lights[3*d +: 3] = 3'b010;
            end else begin
                lights[3*d +: 3] = 3'b100;
            end
        end
    end

    assign grant_dir   = grant_q;
    assign phase       = phase_q;
    assign phase_start = phase_start_q;

endmodule

// File: tb/tb_traffic_ctrl_rr.sv
// Directed testbench for traffic_ctrl_rr with default parameters; follows TL_ALL_RED_EN when defined.
module tb_traffic_ctrl_rr;
    localparam int G  = 8;
    localparam int Y  = 4;
`ifdef TL_ALL_RED_EN
    localparam int AR = 2;
`else
    localparam int AR = 0;
`endif
    localparam int T  = G + Y + AR;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [11:0] lights;
    logic [1:0]  grant_dir;
    logic [1:0]  phase;
    logic        phase_start;

    int testsRun;
    int testsFailed;
    int curCycle;

    int         sched[$];
    logic [3:0] reqPulse[int];
    logic [3:0] reqHold;

    traffic_ctrl_rr dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .lights     (lights),
        .grant_dir  (grant_dir),
        .phase      (phase),
        .phase_start(phase_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        if (obs !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s cycle %0d: got %0h expected %0h", tag, curCycle, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] r);
        req = r;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        req = 4'b0000;
        stepCycle();
        stepCycle();
        rst = 1'b0;
    endtask

    function automatic logic [11:0] lampsFor(input int ph, input int dir);
        logic [11:0] v;
        v = '0;
        for (int d = 0; d < 4; d++) begin
            if (ph == 0 && d == dir)      v[3*d +: 3] = 3'b001;
            else if (ph == 1 && d == dir) v[3*d +: 3] = 3'b010;
            else                          v[3*d +: 3] = 3'b100;
        end
        return v;
    endfunction

    // Expected behaviour from a list of served approaches; the last entry is held in green.
    task automatic runSchedule(input int cycles);
        int last, s, w, ph, dir;
        logic st;
        last = sched.size() - 1;
        for (int c = 0; c < cycles; c++) begin
            curCycle = c;
            applyStimulus(reqHold | (reqPulse.exists(c) ? reqPulse[c] : 4'b0000));
            s = c / T;
            if (s >= last) begin
                dir = sched[last];
                ph  = (c < last * T) ? 0 : 0;
                if (c < last * T) begin
                    w  = c % T;
                    ph = (w < G) ? 0 : (w < G + Y) ? 1 : 2;
                    st = (w == 0 || w == G || w == G + Y);
                    dir = sched[s];
                end else begin
                    ph = 0;
                    st = (c == last * T);
                end
            end else begin
                w   = c % T;
                dir = sched[s];
                ph  = (w < G) ? 0 : (w < G + Y) ? 1 : 2;
                st  = (w == 0 || w == G || w == G + Y);
            end
            checkOutput("lights", 32'(lights), 32'(lampsFor(ph, dir)));
            checkOutput("phase", 32'(phase), 32'(ph));
            checkOutput("grant_dir", 32'(grant_dir), 32'(dir));
            checkOutput("phase_start", 32'(phase_start), 32'(st));
            stepCycle();
        end
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        curCycle    = 0;
        rst         = 1'b1;
        req         = 4'b0000;

        // Idle: approach 0 green forever, one phase_start.
        doReset();
        sched = '{0};
        reqPulse.delete();
        reqHold = 4'b0000;
        runSchedule(50);

        // Single request on approach 2.
        doReset();
        sched = '{0, 2};
        reqPulse.delete();
        reqPulse[3] = 4'b0100;
        reqHold = 4'b0000;
        runSchedule(T + 16);

        // All approaches requesting continuously.
        doReset();
        sched = '{0, 1, 2, 3, 0, 1};
        reqPulse.delete();
        reqHold = 4'b1111;
        runSchedule(4 * T + 8);

        // A request arriving in yellow does not redirect the frozen next approach.
        doReset();
        sched = '{0, 3, 1};
        reqPulse.delete();
        reqPulse[2] = 4'b1000;
        reqPulse[9] = 4'b0010;
        reqHold = 4'b0000;
        runSchedule(2 * T + 10);

        // Reset during yellow discards pending requests.
        doReset();
        sched = '{0, 1};
        reqPulse.delete();
        reqPulse[2] = 4'b0110;
        reqHold = 4'b0000;
        runSchedule(9);
        curCycle = 9;
        applyStimulus(4'b0000);
        checkOutput("yellow_before_rst", 32'(lights), 32'(12'h922));
        rst = 1'b1;
        stepCycle();
        rst = 1'b0;
        sched = '{0};
        reqPulse.delete();
        runSchedule(2 * T);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
